lc3_control_fsm: RTL and testbench

- Instruction-sequencing controller for the SLC-3 datapath.
- Drives every load, gate and mux-select of the datapath, plus the active-low SRAM strobes.
- Runs fetch → decode → execute for ADD, AND, NOT, BR, JMP, JSR, LDR, STR and PAUSE.
- Sits beside the datapath in the top level. Consumes IR[15:0] and BEN from the datapath, and Run/Continue from the board switches.

---
 rtl/lc3_control_fsm.sv | 245 ++++++++++++++++++++++++
 tb/tb_lc3_control_fsm.sv | 360 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lc3_control_fsm.sv
// SLC-3 instruction-sequencing controller: fetch/decode/execute FSM driving datapath loads, gates, selects and SRAM strobes.
// Optional retired-instruction counter output Instr_count enabled by defining CTRL_INSTR_CNT_EN.
module lc3_control_fsm #(
    parameter int MEM_WAIT = 3
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Run,
    input  logic        Continue,
    input  logic [15:0] IR,
    input  logic        BEN,
    output logic        LD_MAR,
    output logic        LD_MDR,
    output logic        LD_IR,
    output logic        LD_BEN,
    output logic        LD_CC,
    output logic        LD_REG,
    output logic        LD_PC,
    output logic        GatePC,
    output logic        GateMDR,
    output logic        GateALU,
    output logic        GateMARMUX,
    output logic [1:0]  PCMUX,
    output logic        DRMUX,
    output logic        SR1MUX,
    output logic        SR2MUX,
    output logic        ADDR1MUX,
    output logic [1:0]  ADDR2MUX,
    output logic [1:0]  ALUK,
    output logic        MIO_EN,
    output logic        Mem_CE,
    output logic        Mem_UB,
    output logic        Mem_LB,
    output logic        Mem_OE,
    output logic        Mem_WE,
    output logic [4:0]  State_dbg
`ifdef CTRL_INSTR_CNT_EN
    ,
    output logic [15:0] Instr_count
`endif
);

    // Handshakes: Run is a level sampled only in HALTED; Continue is a level,
    // high to leave PAUSE1 and low to leave PAUSE2, so one press retires one PAUSE.
    typedef enum logic [4:0] {
        S_HALTED   = 5'd0,
        S_FETCH    = 5'd1,
        S_RD_WAIT  = 5'd2,
        S_LOAD_IR  = 5'd3,
        S_DECODE   = 5'd4,
        S_ADD      = 5'd5,
        S_AND      = 5'd6,
        S_NOT      = 5'd7,
        S_BR       = 5'd8,
        S_JMP      = 5'd9,
        S_JSR1     = 5'd10,
        S_JSR2     = 5'd11,
        S_LDR_ADDR = 5'd12,
        S_STR_ADDR = 5'd13,
        S_LDR_WB   = 5'd14,
        S_STR_MDR  = 5'd15,
        S_WR_WAIT  = 5'd16,
        S_PAUSE1   = 5'd17,
        S_PAUSE2   = 5'd18
    } state_t;

    localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT - 1);

    state_t     state;
    state_t     next_state;
    logic [3:0] wait_cnt;
    logic       load_rd;
    logic       unused_ir;

    assign unused_ir = ^{IR[10:6], IR[4:0]};
    assign State_dbg = state;
    assign Mem_UB    = 1'b0;
    assign Mem_LB    = 1'b0;

    // load_rd remembers whether the current RD_WAIT serves an LDR rather than a fetch.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state    <= S_HALTED;
            wait_cnt <= 4'd0;
            load_rd  <= 1'b0;
        end else begin
            state <= next_state;
            if ((next_state == S_RD_WAIT || next_state == S_WR_WAIT) && next_state != state)
                wait_cnt <= WAIT_INIT;
            else if (wait_cnt != 4'd0)
                wait_cnt <= wait_cnt - 4'd1;
            if (state == S_FETCH)
                load_rd <= 1'b0;
            else if (state == S_LDR_ADDR)
                load_rd <= 1'b1;
        end
    end

`ifdef CTRL_INSTR_CNT_EN
    always_ff @(posedge Clk) begin
        if (!Reset)
            Instr_count <= 16'd0;
        else if (next_state == S_FETCH && state != S_HALTED)
            Instr_count <= Instr_count + 16'd1;
    end
`endif

    always_comb begin
        next_state = state;
        unique case (state)
            S_HALTED:   if (Run) next_state = S_FETCH;
            S_FETCH:    next_state = S_RD_WAIT;
            S_RD_WAIT:  if (wait_cnt == 4'd0) next_state = load_rd ? S_LDR_WB : S_LOAD_IR;
            S_LOAD_IR:  next_state = S_DECODE;
            S_DECODE: begin
                case (IR[15:12])
                    4'b0001: next_state = S_ADD;
                    4'b0101: next_state = S_AND;
                    4'b1001: next_state = S_NOT;
                    4'b0000: next_state = S_BR;
                    4'b1100: next_state = S_JMP;
                    4'b0100: next_state = S_JSR1;
                    4'b0110: next_state = S_LDR_ADDR;
                    4'b0111: next_state = S_STR_ADDR;
                    4'b1101: next_state = S_PAUSE1;
                    default: next_state = S_FETCH;
                endcase
            end
            S_ADD, S_AND, S_NOT, S_BR, S_JMP, S_JSR2, S_LDR_WB: next_state = S_FETCH;
            S_JSR1:     next_state = S_JSR2;
            S_LDR_ADDR: next_state = S_RD_WAIT;
            S_STR_ADDR: next_state = S_STR_MDR;
            S_STR_MDR:  next_state = S_WR_WAIT;
            S_WR_WAIT:  if (wait_cnt == 4'd0) next_state = S_FETCH;
            S_PAUSE1:   if (Continue) next_state = S_PAUSE2;
            S_PAUSE2:   if (!Continue) next_state = S_FETCH;
            default:    next_state = S_HALTED;
        endcase
    end

    always_comb begin
        LD_MAR     = 1'b0;
        LD_MDR     = 1'b0;
        LD_IR      = 1'b0;
        LD_BEN     = 1'b0;
        LD_CC      = 1'b0;
        LD_REG     = 1'b0;
        LD_PC      = 1'b0;
        GatePC     = 1'b0;
        GateMDR    = 1'b0;
        GateALU    = 1'b0;
        GateMARMUX = 1'b0;
        PCMUX      = 2'b00;
        DRMUX      = 1'b0;
        SR1MUX     = 1'b0;
        SR2MUX     = 1'b0;
        ADDR1MUX   = 1'b0;
        ADDR2MUX   = 2'b00;
        ALUK       = 2'b00;
        MIO_EN     = 1'b0;
        Mem_CE     = 1'b1;
        Mem_OE     = 1'b1;
        Mem_WE     = 1'b1;
        unique case (state)
            S_FETCH: begin
                GatePC = 1'b1;
                LD_MAR = 1'b1;
                LD_PC  = 1'b1;
            end
            S_RD_WAIT: begin
                Mem_CE = 1'b0;
                Mem_OE = 1'b0;
                MIO_EN = 1'b1;
                LD_MDR = (wait_cnt == 4'd0);
            end
            S_LOAD_IR: begin
                GateMDR = 1'b1;
                LD_IR   = 1'b1;
            end
            S_DECODE: LD_BEN = 1'b1;
            S_ADD, S_AND, S_NOT: begin
                SR1MUX  = 1'b1;
                GateALU = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
                if (state == S_ADD) ALUK = 2'b00;
                else if (state == S_AND) ALUK = 2'b01;
                else ALUK = 2'b10;
                SR2MUX  = (state != S_NOT) && IR[5];
            end
            S_BR: begin
                if (BEN) begin
                    PCMUX    = 2'b10;
                    ADDR2MUX = 2'b10;
                    LD_PC    = 1'b1;
                end
            end
            S_JMP: begin
                SR1MUX   = 1'b1;
                ADDR1MUX = 1'b1;
                PCMUX    = 2'b10;
                LD_PC    = 1'b1;
            end
            S_JSR1: begin
                GatePC = 1'b1;
                DRMUX  = 1'b1;
                LD_REG = 1'b1;
            end
            // R7 already holds the return address; PC is still the pre-update value here.
            S_JSR2: begin
                PCMUX = 2'b10;
                LD_PC = 1'b1;
                if (IR[11]) begin
                    ADDR2MUX = 2'b11;
                end else begin
                    ADDR1MUX = 1'b1;
                    SR1MUX   = 1'b1;
                end
            end
            S_LDR_ADDR, S_STR_ADDR: begin
                GateMARMUX = 1'b1;
                LD_MAR     = 1'b1;
                ADDR1MUX   = 1'b1;
                ADDR2MUX   = 2'b01;
                SR1MUX     = 1'b1;
            end
            S_LDR_WB: begin
                GateMDR = 1'b1;
                LD_REG  = 1'b1;
                LD_CC   = 1'b1;
            end
            S_STR_MDR: begin
                ALUK    = 2'b11;
                GateALU = 1'b1;
                LD_MDR  = 1'b1;
            end
            S_WR_WAIT: begin
                Mem_CE = 1'b0;
                Mem_WE = 1'b0;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_lc3_control_fsm.sv
// Directed bench for lc3_control_fsm: per-instruction microsequence model feeding an expected queue, checked every cycle.
module tb_lc3_control_fsm;

    localparam int MEM_WAIT = 3;
    localparam int W = 27;

    typedef struct packed {
        logic ld_mar, ld_mdr, ld_ir, ld_ben, ld_cc, ld_reg, ld_pc;
        logic gate_pc, gate_mdr, gate_alu, gate_marmux;
        logic [1:0] pcmux;
        logic drmux, sr1mux, sr2mux, addr1mux;
        logic [1:0] addr2mux;
        logic [1:0] aluk;
        logic mio_en, mem_ce, mem_ub, mem_lb, mem_oe, mem_we;
    } ctl_t;

    logic        Clk = 1'b0;
    logic        Reset, Run, Continue, BEN;
    logic [15:0] IR;
    logic LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC;
    logic GatePC, GateMDR, GateALU, GateMARMUX;
    logic [1:0] PCMUX, ADDR2MUX, ALUK;
    logic DRMUX, SR1MUX, SR2MUX, ADDR1MUX, MIO_EN;
    logic Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE;
    logic [4:0] unused_state_dbg;
`ifdef CTRL_INSTR_CNT_EN
    logic [15:0] Instr_count;
`endif

    lc3_control_fsm #(.MEM_WAIT(MEM_WAIT)) dut (
        .Clk(Clk), .Reset(Reset), .Run(Run), .Continue(Continue), .IR(IR), .BEN(BEN),
        .LD_MAR(LD_MAR), .LD_MDR(LD_MDR), .LD_IR(LD_IR), .LD_BEN(LD_BEN), .LD_CC(LD_CC),
        .LD_REG(LD_REG), .LD_PC(LD_PC), .GatePC(GatePC), .GateMDR(GateMDR), .GateALU(GateALU),
        .GateMARMUX(GateMARMUX), .PCMUX(PCMUX), .DRMUX(DRMUX), .SR1MUX(SR1MUX), .SR2MUX(SR2MUX),
        .ADDR1MUX(ADDR1MUX), .ADDR2MUX(ADDR2MUX), .ALUK(ALUK), .MIO_EN(MIO_EN),
        .Mem_CE(Mem_CE), .Mem_UB(Mem_UB), .Mem_LB(Mem_LB), .Mem_OE(Mem_OE), .Mem_WE(Mem_WE),
        .State_dbg(unused_state_dbg)
`ifdef CTRL_INSTR_CNT_EN
        , .Instr_count(Instr_count)
`endif
    );

    // clock / reset
    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;
    int exp_cnt = 0;
    logic cmp_en = 1'b0;
    logic [W-1:0] exp_q[$];
    ctl_t seq_q[$];
    ctl_t act_w;

    assign act_w = {LD_MAR, LD_MDR, LD_IR, LD_BEN, LD_CC, LD_REG, LD_PC,
                    GatePC, GateMDR, GateALU, GateMARMUX, PCMUX,
                    DRMUX, SR1MUX, SR2MUX, ADDR1MUX, ADDR2MUX, ALUK,
                    MIO_EN, Mem_CE, Mem_UB, Mem_LB, Mem_OE, Mem_WE};

    // model: each instruction is the list of control words it must produce, one per cycle
    function automatic ctl_t idle_w();
        ctl_t w;
        w = '0;
        w.mem_ce = 1'b1;
        w.mem_oe = 1'b1;
        w.mem_we = 1'b1;
        return w;
    endfunction

    task automatic add_read();
        ctl_t w;
        for (int i = 0; i < MEM_WAIT; i++) begin
            w = idle_w();
            w.mem_ce = 1'b0;
            w.mem_oe = 1'b0;
            w.mio_en = 1'b1;
            w.ld_mdr = (i == MEM_WAIT - 1);
            seq_q.push_back(w);
        end
    endtask

    task automatic add_addr();
        ctl_t w;
        w = idle_w();
        w.gate_marmux = 1'b1; w.ld_mar = 1'b1; w.addr1mux = 1'b1; w.addr2mux = 2'b01; w.sr1mux = 1'b1;
        seq_q.push_back(w);
    endtask

    task automatic build_seq(input logic [15:0] ir, input logic ben);
        ctl_t w;
        seq_q.delete();
        w = idle_w(); w.gate_pc = 1'b1; w.ld_mar = 1'b1; w.ld_pc = 1'b1;
        seq_q.push_back(w);
        add_read();
        w = idle_w(); w.gate_mdr = 1'b1; w.ld_ir = 1'b1;
        seq_q.push_back(w);
        w = idle_w(); w.ld_ben = 1'b1;
        seq_q.push_back(w);
        w = idle_w();
        case (ir[15:12])
            4'h1, 4'h5, 4'h9: begin
                w.sr1mux = 1'b1; w.gate_alu = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
                w.aluk = (ir[15:12] == 4'h1) ? 2'd0 : (ir[15:12] == 4'h5) ? 2'd1 : 2'd2;
                w.sr2mux = (ir[15:12] != 4'h9) ? ir[5] : 1'b0;
                seq_q.push_back(w);
            end
            4'h0: begin
                if (ben) begin w.pcmux = 2'd2; w.addr2mux = 2'd2; w.ld_pc = 1'b1; end
                seq_q.push_back(w);
            end
            4'hC: begin
                w.sr1mux = 1'b1; w.addr1mux = 1'b1; w.pcmux = 2'd2; w.ld_pc = 1'b1;
                seq_q.push_back(w);
            end
            4'h4: begin
                w.gate_pc = 1'b1; w.drmux = 1'b1; w.ld_reg = 1'b1;
                seq_q.push_back(w);
                w = idle_w(); w.pcmux = 2'd2; w.ld_pc = 1'b1;
                if (ir[11]) w.addr2mux = 2'd3;
                else begin w.addr1mux = 1'b1; w.sr1mux = 1'b1; end
                seq_q.push_back(w);
            end
            4'h6: begin
                add_addr();
                add_read();
                w = idle_w(); w.gate_mdr = 1'b1; w.ld_reg = 1'b1; w.ld_cc = 1'b1;
                seq_q.push_back(w);
            end
            4'h7: begin
                add_addr();
                w = idle_w(); w.aluk = 2'd3; w.gate_alu = 1'b1; w.ld_mdr = 1'b1;
                seq_q.push_back(w);
                for (int i = 0; i < MEM_WAIT; i++) begin
                    w = idle_w(); w.mem_ce = 1'b0; w.mem_we = 1'b0;
                    seq_q.push_back(w);
                end
            end
            default: ;
        endcase
    endtask

    // driver tasks
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push_n(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(seq_q[i]);
    endtask

    task automatic push_idle();
        exp_q.push_back(idle_w());
    endtask

    task automatic check_len(input string name, input int exp_len);
        checks++;
        if (seq_q.size() != exp_len) begin
            errors++;
            $display("FAIL model_len_%s got=%0d exp=%0d", name, seq_q.size(), exp_len);
        end
    endtask

    task automatic check_bit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%b exp=%b", name, act, exp);
        end
    endtask

    // called at the start of the FETCH cycle; returns at the start of the next FETCH cycle
    task automatic run_instr(input string name, input logic [15:0] ir, input logic ben, input int exp_len);
        int n;
        IR = ir;
        BEN = ben;
        build_seq(ir, ben);
        check_len(name, exp_len);
        n = seq_q.size();
        push_n(n);
        repeat (n) step();
        exp_cnt++;
    endtask

    // scoreboard: one expected control word per cycle
    always @(negedge Clk) begin
        if (cmp_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL ctl_word t=%0t got=%h exp=<empty queue>", $time, act_w);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (act_w !== e) begin
                    errors++;
                    $display("FAIL ctl_word t=%0t got=%h exp=%h", $time, act_w, e);
                end
            end
        end
    end

    // timing monitors: FETCH-to-FETCH spacing and Mem_WE low-run length
    int cyc = 0;
    int last_fetch = 0;
    logic have_fetch = 1'b0;
    int gap_q[$];
    int we_len = 0;
    int we_q[$];

    always @(negedge Clk) begin
        cyc++;
        if (Reset !== 1'b1) begin
            have_fetch = 1'b0;
        end else if (GatePC === 1'b1 && LD_MAR === 1'b1 && LD_PC === 1'b1 && PCMUX === 2'b00) begin
            if (have_fetch) gap_q.push_back(cyc - last_fetch);
            last_fetch = cyc;
            have_fetch = 1'b1;
        end
        if (Mem_WE === 1'b0) we_len++;
        else if (we_len > 0) begin
            we_q.push_back(we_len);
            we_len = 0;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    int exp_gaps[14] = '{7, 7, 7, 7, 7, 7, 8, 8, 11, 11, 6, 16, 7, 7};

    initial begin
        Reset = 1'b0; Run = 1'b0; Continue = 1'b0; IR = 16'h0000; BEN = 1'b0;
        step();
        step();
        // held in reset for two edges: HALTED with default outputs
        cmp_en = 1'b1;
        push_idle();
        Reset = 1'b1;
        repeat (3) begin step(); push_idle(); end
        Run = 1'b1;
        step();
        Run = 1'b0;

        // pin a few model words by hand
        build_seq(16'h1261, 1'b0);
        check_bit("model_decode_ld_ben", seq_q[5].ld_ben, 1'b1);
        check_bit("model_add_sr2mux", seq_q[6].sr2mux, 1'b1);
        check_bit("model_add_ld_cc", seq_q[6].ld_cc, 1'b1);
        build_seq(16'h7042, 1'b0);
        check_bit("model_str_mdr_mio", seq_q[7].mio_en, 1'b0);
        check_bit("model_str_mdr_ld", seq_q[7].ld_mdr, 1'b1);

        run_instr("add",  16'h1261, 1'b0, 7);
        run_instr("and",  16'h5042, 1'b0, 7);
        run_instr("not",  16'h903F, 1'b0, 7);
        run_instr("br_t", 16'h0E02, 1'b1, 7);
        run_instr("br_f", 16'h0E02, 1'b0, 7);
        run_instr("jmp",  16'hC1C0, 1'b0, 7);
        run_instr("jsr",  16'h4802, 1'b0, 8);
        run_instr("jsrr", 16'h4080, 1'b0, 8);
        run_instr("ldr",  16'h6042, 1'b0, 11);
        run_instr("str",  16'h7042, 1'b0, 11);
        run_instr("nop",  16'h8000, 1'b0, 6);

        // PAUSE: three cycles waiting, Continue high six cycles, then released
        IR = 16'hD000;
        build_seq(16'hD000, 1'b0);
        check_len("pause", 6);
        push_n(6);
        repeat (6) step();
        repeat (3) begin push_idle(); step(); end
        Continue = 1'b1;
        push_idle(); step();
        repeat (5) begin push_idle(); step(); end
        Continue = 1'b0;
        push_idle(); step();
        exp_cnt++;

        run_instr("add2", 16'h1261, 1'b0, 7);

`ifdef CTRL_INSTR_CNT_EN
        checks++;
        if (Instr_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL instr_count_pre got=%0d exp=%0d", Instr_count, exp_cnt);
        end
`endif

        // LDR cut short by reset during its second data-read wait cycle
        IR = 16'h6042;
        build_seq(16'h6042, 1'b0);
        push_n(9);
        repeat (8) step();
        Reset = 1'b0;
        step();
        push_idle();
        exp_cnt = 0;
`ifdef CTRL_INSTR_CNT_EN
        checks++;
        if (Instr_count !== 16'd0) begin
            errors++;
            $display("FAIL instr_count_reset got=%0d exp=0", Instr_count);
        end
`endif
        Reset = 1'b1;
        step(); push_idle();
        step(); push_idle();
        Run = 1'b1;
        step();
        // Run left high: must be ignored once running
        run_instr("add3", 16'h1261, 1'b0, 7);
        cmp_en = 1'b0;
        @(negedge Clk);
        #1;

`ifdef CTRL_INSTR_CNT_EN
        checks++;
        if (Instr_count !== 16'(exp_cnt)) begin
            errors++;
            $display("FAIL instr_count_end got=%0d exp=%0d", Instr_count, exp_cnt);
        end
`endif

        checks++;
        if (gap_q.size() != 14) begin
            errors++;
            $display("FAIL fetch_gap_count got=%0d exp=14", gap_q.size());
        end
        for (int i = 0; i < 14 && i < gap_q.size(); i++) begin
            checks++;
            if (gap_q[i] != exp_gaps[i]) begin
                errors++;
                $display("FAIL fetch_gap[%0d] got=%0d exp=%0d", i, gap_q[i], exp_gaps[i]);
            end
        end
        checks++;
        if (we_q.size() != 1) begin
            errors++;
            $display("FAIL we_run_count got=%0d exp=1", we_q.size());
        end else begin
            checks++;
            if (we_q[0] != 3) begin
                errors++;
                $display("FAIL we_run_len got=%0d exp=3", we_q[0]);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected got=%0d exp=0", exp_q.size());
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
